ps2_scan_sequencer: RTL and testbench

- Controller between the PS/2 byte receiver and the consumers of key events.
- Takes received scan-code bytes and their parity-OK flag, and runs the E0/F0 prefix state machine.
- Emits complete key events (code, extended, break) through a FIFO with a valid/ready handshake.
- Gates the receiver enable (EN) for back-pressure and counts protocol errors.

---
 rtl/ps2_scan_sequencer_if.sv | 24 ++
 rtl/ps2_scan_sequencer.sv | 170 +++++++++++++++++
 tb/tb_ps2_scan_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scan_sequencer_if.sv
// Receiver-side byte strobe and consumer-side key-event handshake for ps2_scan_sequencer.
// The slave modport is the sequencer and the master modport is its environment.
interface ps2_scan_sequencer_if;
  logic       rx_tick;
  logic [7:0] rx_byte;
  logic       rx_ok;
  logic       rx_en;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [7:0] err_cnt;

  modport slave (
    input  rx_tick, rx_byte, rx_ok, evt_ready,
    output rx_en, evt_valid, evt_code, evt_ext, evt_break, err_cnt
  );

  modport master (
    output rx_tick, rx_byte, rx_ok, evt_ready,
    input  rx_en, evt_valid, evt_code, evt_ext, evt_break, err_cnt
  );
endinterface

// File: rtl/ps2_scan_sequencer.sv
// PS/2 scan-code sequencer: E0/F0 prefix FSM, show-ahead event FIFO, receiver gating, error count.
// Optional PS2_SEQ_TYPEMATIC_FILTER_EN suppresses repeated make events of the held key.
module ps2_scan_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input logic                 clk,
  input logic                 rst,
  ps2_scan_sequencer_if.slave bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_HIWM = CNT_W'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       err_q, err_d;
  evt_t             mem_q [FIFO_DEPTH];
  evt_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  evt_t             head_q, head_d;
  logic [8:0]       held_q, held_d;
  logic             held_vld_q, held_vld_d;

  logic push_req, push_en, pop, err_inc;
  evt_t push_evt;
  logic is_e0, is_f0;

  assign is_e0 = (bus.rx_byte == 8'hE0);
  assign is_f0 = (bus.rx_byte == 8'hF0);

  // Next-state: prefix FSM, timeout, typematic filter, FIFO bookkeeping and error count
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    push_req   = 1'b0;
    push_evt   = '0;
    err_inc    = 1'b0;
    held_d     = held_q;
    held_vld_d = held_vld_q;

    if (bus.rx_tick) begin
      tmo_d = '0;
      if (!bus.rx_ok) begin
        err_inc = 1'b1;
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (is_e0)                                          state_d = GOT_E0;
            else if (is_f0)                                     state_d = GOT_F0;
            else if (bus.rx_byte == 8'h00 || bus.rx_byte == 8'hFF) err_inc = 1'b1;
            else begin
              push_req = 1'b1;
              push_evt = '{code: bus.rx_byte, ext: 1'b0, brk: 1'b0};
            end
          end
          GOT_E0: begin
            if (is_f0)      state_d = GOT_E0F0;
            else if (!is_e0) begin
              push_req = 1'b1;
              push_evt = '{code: bus.rx_byte, ext: 1'b1, brk: 1'b0};
              state_d  = IDLE;
            end
          end
          GOT_F0, GOT_E0F0: begin
            state_d = IDLE;
            if (is_e0 || is_f0) err_inc = 1'b1;
            else begin
              push_req = 1'b1;
              push_evt = '{code: bus.rx_byte, ext: (state_q == GOT_E0F0), brk: 1'b1};
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q != IDLE) begin
      // A stalled prefix is abandoned so the next byte starts a fresh sequence
      if (tmo_q == TMO_LAST) begin
        state_d = IDLE;
        tmo_d   = '0;
        err_inc = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

`ifdef PS2_SEQ_TYPEMATIC_FILTER_EN
    if (push_req) begin
      if (!push_evt.brk) begin
        if (held_vld_q && held_q == {push_evt.code, push_evt.ext}) begin
          push_req = 1'b0;
        end else begin
          held_d     = {push_evt.code, push_evt.ext};
          held_vld_d = 1'b1;
        end
      end else if (held_vld_q && held_q == {push_evt.code, push_evt.ext}) begin
        held_vld_d = 1'b0;
      end
    end
`endif

    pop     = (count_q != '0) && bus.evt_ready;
    push_en = push_req && ((count_q != CNT_FULL) || pop);
    if (push_req && !push_en) err_inc = 1'b1;

    mem_d = mem_q;
    if (push_en) mem_d[wr_ptr_q] = push_evt;
    wr_ptr_d = push_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (push_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_en && pop) count_d = count_q - CNT_W'(1);

    // Head register gives show-ahead output and holds last fields while empty
    head_d = head_q;
    if (count_d != '0) head_d = mem_d[rd_ptr_d];

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      err_q      <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      held_q     <= '0;
      held_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
    end
  end

  // One slot stays free for a frame the receiver may already be shifting in
  assign bus.rx_en     = (count_q < CNT_HIWM);
  assign bus.evt_valid = (count_q != '0);
  assign bus.evt_code  = head_q.code;
  assign bus.evt_ext   = head_q.ext;
  assign bus.evt_break = head_q.brk;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Scoreboard bench for ps2_scan_sequencer: directed byte sequences push expected events,
// a negedge monitor pops and compares every accepted event.
module tb_ps2_scan_sequencer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 40;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_scan_sequencer_if bus ();

  ps2_scan_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  evt_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each accepted head event with the oldest expectation
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_evt: got %0h expected none", {bus.evt_code, bus.evt_ext, bus.evt_break});
        end else begin
          e = exp_q.pop_front();
          check("evt", {22'b0, bus.evt_code, bus.evt_ext, bus.evt_break}, {22'b0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic ok);
    bus.rx_tick = 1'b1;
    bus.rx_byte = b;
    bus.rx_ok   = ok;
    tick();
    bus.rx_tick = 1'b0;
    bus.rx_byte = 8'h00;
    bus.rx_ok   = 1'b0;
  endtask

  task automatic expect_evt(input logic [7:0] c, input logic x, input logic b);
    exp_q.push_back('{code: c, ext: x, brk: b});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && bus.evt_valid === 1'b0) break;
      tick();
    end
    check({"drain_", name}, 32'(exp_q.size()), 32'd0);
    check({"empty_", name}, 32'(bus.evt_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    tick();
    check("rst_valid", 32'(bus.evt_valid), 32'd0);
    check("rst_err", 32'(bus.err_cnt), 32'd0);
    check("rst_rx_en", 32'(bus.rx_en), 32'd1);
    check("rst_code", {22'b0, bus.evt_code, bus.evt_ext, bus.evt_break}, 32'd0);
    rst = 1'b1;
    tick();
  endtask

  logic [7:0] bp_codes [6] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
  logic       bp_rx_en [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] bp_err   [6] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
  logic [7:0] tm_codes [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};

  initial begin
    rst           = 1'b0;
    bus.rx_tick   = 1'b0;
    bus.rx_byte   = 8'h00;
    bus.rx_ok     = 1'b0;
    bus.evt_ready = 1'b1;
    repeat (2) tick();
    do_reset();

    // Single make code, latency and hold-while-empty
    expect_evt(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b1);
    check("t1_valid", 32'(bus.evt_valid), 32'd1);
    check("t1_code", 32'(bus.evt_code), 32'h1C);
    tick();
    check("t1_valid_drop", 32'(bus.evt_valid), 32'd0);
    check("t1_code_hold", 32'(bus.evt_code), 32'h1C);
    drain("t1");
    check("t1_err", 32'(bus.err_cnt), 32'd0);

    // Extended break
    expect_evt(8'h74, 1'b1, 1'b1);
    send(8'hE0, 1'b1);
    check("t2_pfx_e0", 32'(bus.evt_valid), 32'd0);
    send(8'hF0, 1'b1);
    check("t2_pfx_f0", 32'(bus.evt_valid), 32'd0);
    send(8'h74, 1'b1);
    drain("t2");
    check("t2_err", 32'(bus.err_cnt), 32'd0);

    // Prefix timeout boundary
    do_reset();
    send(8'hF0, 1'b1);
    repeat (TMO - 1) tick();
    check("t3_err_before", 32'(bus.err_cnt), 32'd0);
    tick();
    check("t3_err_after", 32'(bus.err_cnt), 32'd1);
    check("t3_no_evt", 32'(bus.evt_valid), 32'd0);
    expect_evt(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b1);
    drain("t3");
    check("t3_err_final", 32'(bus.err_cnt), 32'd1);

    // Back-pressure, rx_en gating and overflow drop
    do_reset();
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) expect_evt(bp_codes[i], 1'b0, 1'b0);
      send(bp_codes[i], 1'b1);
      check($sformatf("t4_rx_en_%0d", i), 32'(bus.rx_en), 32'(bp_rx_en[i]));
      check($sformatf("t4_err_%0d", i), 32'(bus.err_cnt), 32'(bp_err[i]));
      check($sformatf("t4_head_%0d", i), 32'(bus.evt_code), 32'h15);
    end
    bus.evt_ready = 1'b1;
    drain("t4");
    check("t4_rx_en_after", 32'(bus.rx_en), 32'd1);

    // Bad parity inside an E0 prefix
    do_reset();
    send(8'hE0, 1'b1);
    send(8'hAA, 1'b0);
    check("t5_err", 32'(bus.err_cnt), 32'd1);
    expect_evt(8'h75, 1'b0, 1'b0);
    send(8'h75, 1'b1);
    drain("t5");
    check("t5_err_final", 32'(bus.err_cnt), 32'd1);

    // Typematic repeats
    do_reset();
`ifdef PS2_SEQ_TYPEMATIC_FILTER_EN
    expect_evt(8'h1C, 1'b0, 1'b0);
    expect_evt(8'h1C, 1'b0, 1'b1);
    expect_evt(8'h1C, 1'b0, 1'b0);
`else
    expect_evt(8'h1C, 1'b0, 1'b0);
    expect_evt(8'h1C, 1'b0, 1'b0);
    expect_evt(8'h1C, 1'b0, 1'b0);
    expect_evt(8'h1C, 1'b0, 1'b1);
    expect_evt(8'h1C, 1'b0, 1'b0);
`endif
    for (int i = 0; i < 6; i++) send(tm_codes[i], 1'b1);
    drain("t6");
    check("t6_err", 32'(bus.err_cnt), 32'd0);

    // Protocol errors: prefix after F0, and reserved bytes in IDLE
    do_reset();
    send(8'hF0, 1'b1);
    send(8'hE0, 1'b1);
    check("t7_f0_e0", 32'(bus.err_cnt), 32'd1);
    send(8'hF0, 1'b1);
    send(8'hF0, 1'b1);
    check("t7_f0_f0", 32'(bus.err_cnt), 32'd2);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    check("t7_reserved", 32'(bus.err_cnt), 32'd4);
    check("t7_no_evt", 32'(bus.evt_valid), 32'd0);

    // Reset mid-sequence discards queued events and a partial prefix
    bus.evt_ready = 1'b0;
    send(8'h21, 1'b1);
    send(8'h22, 1'b1);
    send(8'hE0, 1'b1);
    do_reset();
    bus.evt_ready = 1'b1;
    expect_evt(8'h23, 1'b0, 1'b0);
    send(8'h23, 1'b1);
    drain("t8");

    // Push and pop in the same cycle while full
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_evt(8'h31 + 8'(i), 1'b0, 1'b0);
      send(8'h31 + 8'(i), 1'b1);
    end
    bus.evt_ready = 1'b1;
    expect_evt(8'h35, 1'b0, 1'b0);
    send(8'h35, 1'b1);
    check("t9_head", 32'(bus.evt_code), 32'h32);
    drain("t9");
    check("t9_err", 32'(bus.err_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
